// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide engine.
// The control unit drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_multu;
    logic             start_divu;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_multu, start_divu, rs_data, rt_data, mf_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start_multu, start_divu, rs_data, rt_data, mf_req,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU engine owning HI/LO; one shift-add or restoring step per cycle.
// Optional MULDIV_EARLY_OUT_EN: rt==0 at accept bypasses the iterations and finishes next cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset_n,
    muldiv_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;
    logic                 accept;

    // acc_q is shared: {partial product, multiplier} for MUL, {remainder, dividend} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_sh >= {1'b0, opb_q});
        div_diff  = div_sh[WIDTH-1:0] - opb_q;
        div_next  = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        step_next = (state_q == S_MUL) ? mul_next : div_next;
    end

    assign accept = ((state_q == S_IDLE) || (state_q == S_FIN)) &&
                    (bus.start_multu || bus.start_divu);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (accept) begin
                    opb_d   = bus.rt_data;
                    acc_d   = {{WIDTH{1'b0}}, bus.rs_data};
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = bus.start_multu ? S_MUL : S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
                    if (bus.rt_data == '0) begin
                        state_d = S_FIN;
                        hi_d    = bus.start_multu ? '0 : bus.rs_data;
                        lo_d    = bus.start_multu ? '0 : '1;
                    end
`endif
                end else if (state_q == S_FIN) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = step_next;
                if (cnt_q == '0) begin
                    // Final step result goes straight into HI/LO so it is readable in FIN.
                    state_d = S_FIN;
                    hi_d    = step_next[2*WIDTH-1:WIDTH];
                    lo_d    = step_next[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.done  = (state_q == S_FIN);
    assign bus.stall = bus.busy & bus.mf_req;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one operation now, follows it to its done cycle and leaves time there.
    // inject>0 pulses both starts during that busy cycle; they must be ignored.
    task automatic run_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit mf, input int inject, input string tag);
        logic [2*W-1:0] full;
        logic [W-1:0]   nh, nl, ph, pl;
        int             lat, bad, exp_lat;
        if (is_mul) begin
            full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            nh   = full[2*W-1:W];
            nl   = full[W-1:0];
        end else if (b == '0) begin
            nh = a;
            nl = '1;
        end else begin
            nh = a % b;
            nl = a / b;
        end
`ifdef MULDIV_EARLY_OUT_EN
        exp_lat = (b == '0) ? 1 : int'(W) + 1;
`else
        exp_lat = int'(W) + 1;
`endif
        ph = exp_hi;
        pl = exp_lo;
        bus.start_multu = is_mul;
        bus.start_divu  = !is_mul;
        bus.rs_data     = a;
        bus.rt_data     = b;
        bus.mf_req      = mf;
        step();
        bus.start_multu = 1'b0;
        bus.start_divu  = 1'b0;
        bus.rs_data     = $urandom;
        bus.rt_data     = $urandom;
        lat = 1;
        bad = 0;
        while (bus.done !== 1'b1 && lat <= int'(W) + 8) begin
            if (bus.busy !== 1'b1 || bus.stall !== mf || bus.hi !== ph || bus.lo !== pl) bad++;
            if (lat == inject) begin
                bus.start_multu = 1'b1;
                bus.start_divu  = 1'b1;
            end
            step();
            bus.start_multu = 1'b0;
            bus.start_divu  = 1'b0;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy/stall/hold"}, bad, 0);
        check({tag, " busy in FIN"}, bus.busy, 1'b0);
        check({tag, " stall in FIN"}, bus.stall, 1'b0);
        check({tag, " hi"}, bus.hi, nh);
        check({tag, " lo"}, bus.lo, nl);
        exp_hi     = nh;
        exp_lo     = nl;
        bus.mf_req = 1'b0;
    endtask

    initial begin
        int dcount;
        bus.start_multu = 1'b0;
        bus.start_divu  = 1'b0;
        bus.rs_data     = '0;
        bus.rt_data     = '0;
        bus.mf_req      = 1'b1;
        #12;
        check("reset busy",  bus.busy,  1'b0);
        check("reset done",  bus.done,  1'b0);
        check("reset stall", bus.stall, 1'b0);
        check("reset hi",    bus.hi,    '0);
        check("reset lo",    bus.lo,    '0);
        bus.mf_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "t1 multu max");
        step();
        check("t1 done single", bus.done, 1'b0);

        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, "t2 divu 100/7");
        step();
        check("t2 done single", bus.done, 1'b0);

        run_op(1'b0, 32'h1234, 32'd0, 1'b0, 0, "t3 divu by zero");
        step();
        run_op(1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, "t3b multu by zero");
        step();

        run_op(1'b1, 32'd3, 32'd5, 1'b1, 0, "t4 multu stall");
        step();

        run_op(1'b0, 32'd50, 32'd3, 1'b0, 5, "t5 divu ignore start");
        // Back-to-back: the next request is issued in the FIN cycle.
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, 0, "b2b multu");
        step();

        run_op(1'b0, 32'd87, 32'd10, 1'b0, 0, "t6 preload");
        step();
        bus.start_multu = 1'b1;
        bus.rs_data     = 32'd9;
        bus.rt_data     = 32'd9;
        step();
        bus.start_multu = 1'b0;
        repeat (9) step();
        check("t6 busy before reset", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6 busy after reset", bus.busy, 1'b0);
        check("t6 done after reset", bus.done, 1'b0);
        check("t6 hi after reset", bus.hi, '0);
        check("t6 lo after reset", bus.lo, '0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) step();
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dcount++;
        end
        check("t6 no done after abort", dcount, 0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            int unsigned  mode;
            ra   = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       begin rb = $urandom; ra = ra >> $urandom_range(0, 31); end
                default: rb = $urandom;
            endcase
            run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 0,
                   $sformatf("rand%0d", i));
            if (i % 2 == 0) begin
                step();
                check($sformatf("rand%0d done single", i), bus.done, 1'b0);
            end
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
